shift_merge_pipe: RTL and testbench

- Parametrised, 2-stage pipelined shift-merge unit for the execute stage.
- Implements field extract (zero/sign), deposit (merge/zero), double-shift-right and shift-left-and-add.
- Width is generic.
- Valid/ready handshakes on both sides, so the unit tolerates back-pressure from the writeback path.

---
 rtl/shift_merge_pipe.sv | 179 +++++++++++++++++
 tb/tb_shift_merge_pipe.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_merge_pipe.sv
// Two-stage shift-merge unit: field extract/deposit, double-shift-right and shift-left-and-add.
// Operands and results use big-endian bit numbering (bit 0 is the MSB).
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module shift_merge_pipe #(
  parameter int unsigned WIDTH = `WORD_LENGTH,
  parameter int unsigned PW    = $clog2(WIDTH),
  parameter int unsigned LW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [0:WIDTH-1] in_a,
  input  logic [0:WIDTH-1] in_b,
  input  logic [PW-1:0]    in_pos,
  input  logic [LW-1:0]    in_len,
  input  logic [PW-1:0]    in_sa,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_r,
  output logic             out_z,
  output logic             out_n,
  output logic             out_ovf,
  output logic             out_err
);

  localparam logic [2:0] OpExtru = 3'd0;
  localparam logic [2:0] OpExtrs = 3'd1;
  localparam logic [2:0] OpDep   = 3'd2;
  localparam logic [2:0] OpDepz  = 3'd3;
  localparam logic [2:0] OpDsr   = 3'd4;
  localparam logic [2:0] OpShla  = 3'd5;

  // Internally everything is little-endian; the positional copy keeps numeric values.
  logic [WIDTH-1:0] a_v, b_v;
  assign a_v = in_a;
  assign b_v = in_b;

  logic             s1_valid_q, s2_valid_q;
  logic             s2_adv, s1_load, s2_load;
  logic [WIDTH-1:0] s1_x_q, s1_m_q, s1_y_q;
  logic             s1_add_q, s1_err_q, s1_lost_q;
  logic [WIDTH-1:0] x_d, m_d, y_d, low_mask, shla_v;
  logic             add_d, err_d, lost_d, sign;
  logic [LW-1:0]    pos_p1, l_eff;
  logic [PW-1:0]    lp, sidx;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s2_adv && s1_valid_q;

  // Stage 1: clip the field, build shifted data, mask and merge base.
  always_comb begin
    pos_p1   = LW'(in_pos) + LW'(1);
    l_eff    = (in_len < pos_p1) ? in_len : pos_p1;
    lp       = ~in_pos;
    low_mask = ~({WIDTH{1'b1}} << l_eff);
    sidx     = PW'(LW'(lp) + l_eff - LW'(1));
    sign     = (l_eff != '0) && a_v[sidx];
    shla_v   = a_v << in_sa;
    x_d      = '0;
    m_d      = '0;
    y_d      = '0;
    add_d    = 1'b0;
    err_d    = 1'b0;
    lost_d   = 1'b0;
    case (in_op)
      OpExtru: begin
        x_d = a_v >> lp;
        m_d = low_mask;
      end
      OpExtrs: begin
        x_d = a_v >> lp;
        m_d = low_mask;
        y_d = {WIDTH{sign}};
      end
      OpDep: begin
        x_d = a_v << lp;
        m_d = low_mask << lp;
        y_d = b_v;
      end
      OpDepz: begin
        x_d = a_v << lp;
        m_d = low_mask << lp;
      end
      OpDsr: begin
        x_d = WIDTH'({a_v, b_v} >> in_sa);
        m_d = '1;
      end
      OpShla: begin
        if (in_sa > PW'(3)) begin
          err_d = 1'b1;
        end else begin
          x_d   = shla_v;
          y_d   = b_v;
          add_d = 1'b1;
          // Any bit shifted out must match the sign of the shifted value.
          for (int unsigned i = 0; i < 3; i++) begin
            if (PW'(i) < in_sa && a_v[WIDTH-1-i] != shla_v[WIDTH-1]) lost_d = 1'b1;
          end
        end
      end
      default: err_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_x_q    <= x_d;
      s1_m_q    <= m_d;
      s1_y_q    <= y_d;
      s1_add_q  <= add_d;
      s1_err_q  <= err_d;
      s1_lost_q <= lost_d;
    end
  end

  // Stage 2: merge or add, then derive flags.
  logic [WIDTH-1:0] sum, r_d, r_q;
  logic             ovf_d, ovf_q, err_q, z_q, n_q;

  always_comb begin
    sum   = s1_x_q + s1_y_q;
    r_d   = '0;
    ovf_d = 1'b0;
    if (!s1_err_q) begin
      if (s1_add_q) begin
        r_d   = sum;
        ovf_d = s1_lost_q ||
                (s1_x_q[WIDTH-1] == s1_y_q[WIDTH-1] && sum[WIDTH-1] != s1_x_q[WIDTH-1]);
      end else begin
        r_d = (s1_x_q & s1_m_q) | (s1_y_q & ~s1_m_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s2_adv)   s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (s2_load) begin
      r_q   <= r_d;
      z_q   <= (r_d == '0);
      n_q   <= r_d[WIDTH-1];
      ovf_q <= ovf_d;
      err_q <= s1_err_q;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_r     = r_q;
  assign out_z     = z_q;
  assign out_n     = n_q;
  assign out_ovf   = ovf_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_shift_merge_pipe.sv
// Self-checking bench for shift_merge_pipe (WIDTH=32) using an in-order result scoreboard.
module tb_shift_merge_pipe;
  localparam int W = 32;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  pos;
    logic [5:0]  len;
    logic [4:0]  sa;
  } op_t;

  typedef struct {
    logic [31:0] r;
    logic        ovf, err;
  } exp_t;

  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic         in_ready, out_valid, out_z, out_n, out_ovf, out_err;
  logic [2:0]   in_op = '0;
  logic [0:W-1] in_a = '0, in_b = '0, out_r;
  logic [4:0]   in_pos = '0, in_sa = '0;
  logic [5:0]   in_len = '0;

  int checks = 0;
  int errors = 0;
  op_t  ops[$];
  exp_t exps[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  shift_merge_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_pos(in_pos), .in_len(in_len), .in_sa(in_sa),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_z(out_z), .out_n(out_n),
    .out_ovf(out_ovf), .out_err(out_err)
  );

  // Reference model written in big-endian bit terms.
  function automatic exp_t model(input op_t o);
    exp_t        e;
    logic [0:31] a_be, b_be, r_be;
    logic [63:0] cat;
    longint      sh, s;
    logic [31:0] r32;
    int          l, pos;
    logic        sgn;
    a_be = o.a; b_be = o.b; r_be = '0;
    pos = int'(o.pos);
    l = int'(o.len);
    if (l > pos + 1) l = pos + 1;
    if (l > 32) l = 32;
    e.ovf = 1'b0; e.err = 1'b0;
    case (o.op)
      3'd0, 3'd1: begin
        for (int k = 0; k < l; k++) r_be[31-k] = a_be[pos-k];
        if (o.op == 3'd1 && l > 0) begin
          sgn = a_be[pos-l+1];
          for (int k = l; k < 32; k++) r_be[31-k] = sgn;
        end
      end
      3'd2, 3'd3: begin
        r_be = (o.op == 3'd2) ? b_be : '0;
        for (int k = 0; k < l; k++) r_be[pos-k] = a_be[31-k];
      end
      3'd4: begin
        cat = {o.a, o.b};
        r_be = cat[int'(o.sa) +: 32];
      end
      3'd5: begin
        if (o.sa > 5'd3) begin
          e.err = 1'b1;
        end else begin
          sh = longint'($signed(o.a)) * (longint'(1) << o.sa);
          if (sh > 64'sd2147483647 || sh < -64'sd2147483648) e.ovf = 1'b1;
          r32 = sh[31:0];
          s = longint'($signed(r32)) + longint'($signed(o.b));
          if (s > 64'sd2147483647 || s < -64'sd2147483648) e.ovf = 1'b1;
          r_be = s[31:0];
        end
      end
      default: e.err = 1'b1;
    endcase
    e.r = r_be;
    return e;
  endfunction

  task automatic drive(input op_t o);
    in_op = o.op; in_a = o.a; in_b = o.b; in_pos = o.pos; in_len = o.len; in_sa = o.sa;
  endtask

  task automatic add_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int pos, input int len, input int sa,
                        input logic [31:0] r, input logic ovf, input logic err);
    op_t o; exp_t e;
    o.op = op; o.a = a; o.b = b; o.pos = 5'(pos); o.len = 6'(len); o.sa = 5'(sa);
    e.r = r; e.ovf = ovf; e.err = err;
    ops.push_back(o); exps.push_back(e);
  endtask

  // Feeds ops[] in order, scoreboarding accepted ops and checking every delivered result.
  task automatic run_stream(input string name, input bit pattern);
    int   idx = 0;
    int   cyc = 0;
    bit   stall_prev = 1'b0;
    logic [31:0] held = '0;
    exp_t e;
    while ((idx < ops.size() || sb.size() != 0) && cyc < 300) begin
      @(negedge clk);
      out_ready = pattern ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      #1;
      checks++;
      if (in_ready !== (sb.size() < 2 || out_ready)) begin
        errors++;
        $display("FAIL %s in_ready: got %b want %b (in flight %0d)", name, in_ready,
                 (sb.size() < 2 || out_ready), sb.size());
      end
      if (sb.size() == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s spurious out_valid: got %b want 0", name, out_valid);
        end
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_r !== held) begin
          errors++;
          $display("FAIL %s stall hold: got v=%b r=%h want v=1 r=%h", name, out_valid, out_r, held);
        end
      end
      if (out_valid === 1'b1 && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        if (out_r !== e.r) begin
          errors++;
          $display("FAIL %s result: got %h want %h", name, out_r, e.r);
        end
        checks++;
        if ({out_z, out_n, out_ovf, out_err} !== {(e.r == 32'd0), e.r[31], e.ovf, e.err}) begin
          errors++;
          $display("FAIL %s flags z/n/ovf/err: got %b%b%b%b want %b%b%b%b (r=%h)", name,
                   out_z, out_n, out_ovf, out_err, (e.r == 32'd0), e.r[31], e.ovf, e.err, e.r);
        end
      end
      stall_prev = (out_valid === 1'b1) && !out_ready;
      held = out_r;
      if (idx < ops.size()) begin
        drive(ops[idx]);
        in_valid = 1'b1;
        if (in_ready) begin
          sb.push_back(exps[idx]);
          idx++;
        end
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (sb.size() != 0 || idx != ops.size()) begin
      errors++;
      $display("FAIL %s timeout: pending %0d sent %0d of %0d", name, sb.size(), idx, ops.size());
    end
    ops.delete(); exps.delete(); sb.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, out_r, out_z, out_n, out_ovf, out_err} !== 37'd0) begin
      errors++;
      $display("FAIL reset outputs: got v=%b r=%h z=%b n=%b o=%b e=%b want all 0",
               out_valid, out_r, out_z, out_n, out_ovf, out_err);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    in_op = 3'd0; in_a = 32'h12345678; in_pos = 5'd23; in_len = 6'd8; in_sa = '0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency early valid: got %b want 0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_r !== 32'h00000056 || out_z !== 1'b0 || out_n !== 1'b0) begin
      errors++;
      $display("FAIL latency result: got v=%b r=%h z=%b n=%b want v=1 r=00000056 z=0 n=0",
               out_valid, out_r, out_z, out_n);
    end
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_ops();
    add_op(3'd0, 32'h12345678, 32'h0, 23, 8, 0, 32'h00000056, 0, 0);
    add_op(3'd1, 32'h000000F0, 32'h0, 31, 8, 0, 32'hFFFFFFF0, 0, 0);
    add_op(3'd2, 32'h000000AB, 32'h11223344, 15, 8, 0, 32'h11AB3344, 0, 0);
    add_op(3'd3, 32'h000000AB, 32'h11223344, 15, 8, 0, 32'h00AB0000, 0, 0);
    add_op(3'd2, 32'h000000AB, 32'h11223344, 15, 0, 0, 32'h11223344, 0, 0);
    add_op(3'd0, 32'hA0000000, 32'h0, 3, 8, 0, 32'h0000000A, 0, 0);
    add_op(3'd1, 32'hFFFFFFFF, 32'h0, 20, 0, 0, 32'h00000000, 0, 0);
    add_op(3'd0, 32'hDEADBEEF, 32'h0, 31, 40, 0, 32'hDEADBEEF, 0, 0);
    add_op(3'd4, 32'h00000001, 32'h0, 0, 0, 4, 32'h10000000, 0, 0);
    add_op(3'd4, 32'h00000005, 32'h12345678, 0, 0, 0, 32'h12345678, 0, 0);
    add_op(3'd5, 32'h40000000, 32'h0, 0, 0, 1, 32'h80000000, 1, 0);
    add_op(3'd5, 32'h00000003, 32'h1, 0, 0, 2, 32'h0000000D, 0, 0);
    add_op(3'd5, 32'h7FFFFFFF, 32'h1, 0, 0, 0, 32'h80000000, 1, 0);
    add_op(3'd5, 32'h00000003, 32'h1, 0, 0, 5, 32'h00000000, 0, 1);
    add_op(3'd7, 32'h12345678, 32'h1, 7, 4, 1, 32'h00000000, 0, 1);
    add_op(3'd6, 32'h12345678, 32'h1, 7, 4, 1, 32'h00000000, 0, 1);
    run_stream("directed", 1'b0);
  endtask

  task automatic test_back_to_back();
    op_t o;
    for (int i = 0; i < 10; i++) begin
      o.op  = 3'($urandom_range(0, 7));
      o.a   = $urandom;
      o.b   = $urandom;
      o.pos = 5'($urandom_range(0, 31));
      o.len = 6'($urandom_range(0, 40));
      o.sa  = (o.op == 3'd5) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      ops.push_back(o);
      exps.push_back(model(o));
    end
    run_stream("back_to_back", 1'b1);
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    in_op = 3'd0; in_a = 32'h12345678; in_pos = 5'd23; in_len = 6'd8; in_valid = 1'b1;
    @(negedge clk);
    in_op = 3'd3; in_a = 32'h000000AB;  in_pos = 5'd15;
    @(negedge clk);
    in_op = 3'd2; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush clear: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush stale result cycle %0d: got out_valid=%b want 0", i, out_valid);
      end
    end
    add_op(3'd3, 32'h000000AB, 32'h11223344, 15, 8, 0, 32'h00AB0000, 0, 0);
    run_stream("after_flush", 1'b0);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_op = 3'd0; in_a = 32'h12345678; in_pos = 5'd23; in_len = 6'd8; in_valid = 1'b1;
    @(negedge clk);
    in_op = 3'd1; in_a = 32'h000000F0; in_pos = 5'd31;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst prefill: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_r, out_z, out_n, out_ovf, out_err} !== 37'd0) begin
      errors++;
      $display("FAIL arst immediate: got v=%b r=%h z=%b n=%b o=%b e=%b want all 0",
               out_valid, out_r, out_z, out_n, out_ovf, out_err);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL arst release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL arst spurious cycle %0d: got out_valid=%b want 0", i, out_valid);
      end
    end
    add_op(3'd0, 32'h12345678, 32'h0, 23, 8, 0, 32'h00000056, 0, 0);
    run_stream("after_arst", 1'b0);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
